// File: rtl/pattern_scan_sched.sv
// Round-robin scheduler sharing one serial Mealy sequence detector between
// two requesters: grants a word, clears the detector, shifts the word in
// MSB-first, counts det_z pulses and returns the count with a done strobe.
//
// Ports:
//   clk, rst              clock; asynchronous active-low reset
//   req0_* / req1_*       valid/ready/data word handshakes (ready only in IDLE)
//   det_clr, det_en       detector clear strobe and bit-valid qualifier
//   det_x, det_z          serial bit to the detector, its Mealy match output
//   busy, done, done_id   activity flag, result strobe and result owner
//   match_cnt             saturating match count, held from done to next clear
module pattern_scan_sched #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_data,
    output logic             req1_ready,
    output logic             det_clr,
    output logic             det_en,
    output logic             det_x,
    input  logic             det_z,
    output logic             busy,
    output logic             done,
    output logic             done_id,
    output logic [CNT_W-1:0] match_cnt
);

    localparam int BW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [BW-1:0] LAST = BW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        SHIFT,
        REPORT
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] sreg;
    logic [BW-1:0]    bcnt;
    logic [CNT_W-1:0] cnt;
    logic             id;
    logic             prio;
    logic             want;
    logic             pick;

    // prio names the requester that wins a tie (the one not granted last)
    assign want = req0_valid | req1_valid;
    assign pick = (req0_valid & req1_valid) ? prio : req1_valid;

    assign match_cnt = cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        det_clr    = 1'b0;
        det_en     = 1'b0;
        det_x      = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        done_id    = 1'b0;
        unique case (state)
            IDLE: begin
                busy = 1'b0;
                // rst gating keeps ready low while reset is held
                if (rst && want) begin
                    req0_ready = ~pick;
                    req1_ready = pick;
                    state_nx   = CLEAR;
                end
            end
            CLEAR: begin
                det_clr  = 1'b1;
                state_nx = SHIFT;
            end
            SHIFT: begin
                det_en = 1'b1;
                det_x  = sreg[WIDTH-1];
                if (bcnt == LAST) begin
                    state_nx = REPORT;
                end
            end
            REPORT: begin
                done     = 1'b1;
                done_id  = id;
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sreg <= '0;
            bcnt <= '0;
            cnt  <= '0;
            id   <= 1'b0;
            prio <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (want) begin
                        sreg <= pick ? req1_data : req0_data;
                        id   <= pick;
                        prio <= ~pick;
                    end
                end
                CLEAR: begin
                    cnt  <= '0;
                    bcnt <= '0;
                end
                SHIFT: begin
                    sreg <= {sreg[WIDTH-2:0], 1'b0};
                    bcnt <= bcnt + 1'b1;
                    if (det_z && (cnt != '1)) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pattern_scan_sched.sv
// Bench for pattern_scan_sched: reference "1011" detector drives det_z,
// a phase-based model is compared against the DUT every cycle.
module tb_pattern_scan_sched;

    localparam int W = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       r0v = 1'b0;
    logic       r1v = 1'b0;
    logic [7:0] r0d = '0;
    logic [7:0] r1d = '0;
    logic       r0r, r1r, det_clr, det_en, det_x, det_z;
    logic       busy, done, done_id;
    logic [3:0] match_cnt;

    logic        b0v = 1'b0;
    logic        b1v = 1'b0;
    logic [15:0] b0d = '0;
    logic [15:0] b1d = '0;
    logic        b0r, b1r, b_clr, b_en, b_x, b_z;
    logic        b_busy, b_done, b_did;
    logic [1:0]  b_cnt;

    pattern_scan_sched #(.WIDTH(8), .CNT_W(4)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(r0v), .req0_data(r0d), .req0_ready(r0r),
        .req1_valid(r1v), .req1_data(r1d), .req1_ready(r1r),
        .det_clr(det_clr), .det_en(det_en), .det_x(det_x), .det_z(det_z),
        .busy(busy), .done(done), .done_id(done_id), .match_cnt(match_cnt)
    );

    pattern_scan_sched #(.WIDTH(16), .CNT_W(2)) u16 (
        .clk(clk), .rst(rst),
        .req0_valid(b0v), .req0_data(b0d), .req0_ready(b0r),
        .req1_valid(b1v), .req1_data(b1d), .req1_ready(b1r),
        .det_clr(b_clr), .det_en(b_en), .det_x(b_x), .det_z(b_z),
        .busy(b_busy), .done(b_done), .done_id(b_did), .match_cnt(b_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    function automatic int win_count(input logic [15:0] w, input int n);
        int c;
        c = 0;
        for (int i = 0; i + 4 <= n; i++)
            if (w[n-1-i] && !w[n-2-i] && w[n-3-i] && w[n-4-i]) c++;
        return c;
    endfunction

    // reference overlapping "1011" Mealy detectors
    logic [2:0] dh;
    int         dl;
    logic       mz;
    logic       z_force = 1'b0;
    always @(posedge clk or negedge rst)
        if (!rst) begin
            dh <= '0; dl <= 0;
        end else if (det_clr) begin
            dh <= '0; dl <= 0;
        end else if (det_en) begin
            dh <= {dh[1:0], det_x}; dl <= dl + 1;
        end
    assign mz = det_en && (dl >= 3) && ({dh, det_x} == 4'b1011);
    assign det_z = det_en ? mz : z_force;

    logic [2:0] bh;
    int         bl;
    always @(posedge clk or negedge rst)
        if (!rst) begin
            bh <= '0; bl <= 0;
        end else if (b_clr) begin
            bh <= '0; bl <= 0;
        end else if (b_en) begin
            bh <= {bh[1:0], b_x}; bl <= bl + 1;
        end
    assign b_z = b_en && (bl >= 3) && ({bh, b_x} == 4'b1011);

    // behavioural model: ph = cycles since grant (0 = idle)
    int         ph = 0;
    int         prio = 0;
    int         cid = 0;
    int         held = 0;
    int         m_win;
    int         m_exp;
    logic [7:0] cw = '0;
    logic       m_any, e_en;

    initial forever begin
        @(negedge clk);
        if (!rst) begin
            chk("reset_outputs",
                {r0r, r1r, det_clr, det_en, det_x, busy, done, done_id,
                 match_cnt}, 0);
            ph = 0; prio = 0; held = 0;
        end else begin
            m_any = r0v || r1v;
            m_win = (r0v && r1v) ? prio : (r1v ? 1 : 0);
            m_exp = win_count({8'h00, cw}, W);
            if (m_exp > 15) m_exp = 15;
            e_en  = (ph >= 2) && (ph <= W + 1);
            chk("req0_ready", r0r, ph == 0 && m_any && m_win == 0);
            chk("req1_ready", r1r, ph == 0 && m_any && m_win == 1);
            chk("det_clr", det_clr, ph == 1);
            chk("det_en", det_en, e_en);
            chk("det_x", det_x, e_en ? cw[W+1-ph] : 1'b0);
            chk("busy", busy, ph != 0);
            chk("done", done, ph == W + 2);
            if (ph == W + 2) begin
                chk("done_id", done_id, cid);
                chk("match_cnt_done", match_cnt, m_exp);
            end else if (ph <= 1) begin
                chk("match_cnt_held", match_cnt, held);
            end
            if (ph == 0) begin
                if (m_any) begin
                    cid  = m_win;
                    cw   = (m_win == 1) ? r1d : r0d;
                    prio = 1 - m_win;
                    ph   = 1;
                end
            end else if (ph == W + 2) begin
                held = m_exp;
                ph   = 0;
            end else begin
                ph++;
            end
        end
    end

    // result log and serial bit capture
    int         dl_q[$];
    int         di_q[$];
    int         dc_q[$];
    int         gl[$];
    logic [7:0] xs = '0;
    int         bzc = 0;
    initial forever begin
        @(negedge clk);
        if (rst && done) begin
            dl_q.push_back(cyc + 1);
            di_q.push_back(int'(done_id));
            dc_q.push_back(int'(match_cnt));
        end
        if (det_en) xs = {xs[6:0], det_x};
        if (b_en && b_z) bzc++;
    end

    task automatic send(input int id, input logic [7:0] d, output int t);
        t = -1;
        if (id == 0) begin r0v = 1'b1; r0d = d; end
        else begin r1v = 1'b1; r1d = d; end
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (id == 0 ? (r0v && r0r) : (r1v && r1r)) begin
                t = cyc + 1;
                break;
            end
        end
        chk("accept_in_time", t >= 0, 1);
        if (t >= 0) gl.push_back(id);
        @(posedge clk);
        #1;
        if (id == 0) r0v = 1'b0;
        else r1v = 1'b0;
    endtask

    task automatic wait_done(input int n);
        for (int i = 0; i < 400 && dl_q.size() < n; i++) @(negedge clk);
        chk("done_in_time", dl_q.size() >= n, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        dl_q.delete(); di_q.delete(); dc_q.delete(); gl.delete();
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic rnd_req(input int id);
        int t;
        repeat ($urandom_range(1, 3)) begin
            repeat ($urandom_range(0, 12)) @(posedge clk);
            #1;
            send(id, 8'($urandom), t);
        end
    endtask

    logic rnd_on = 1'b0;
    initial forever begin
        @(posedge clk);
        #1;
        if (rnd_on) z_force = 1'($urandom_range(0, 1));
    end

    int t0, t1, ta, tb, td, tc, n0;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_u16_busy", b_busy, 0);
        rst = 1'b1;

        // single word from req0
        clear_logs();
        send(0, 8'b1011_0110, t0);
        wait_done(1);
        chk("t1_latency", dl_q[0] - t0, 10);
        chk("t1_id", di_q[0], 0);
        chk("t1_cnt", dc_q[0], 2);
        chk("t1_bits", xs, 8'b1011_0110);

        // both valid from reset, re-raised after each accept
        do_reset();
        clear_logs();
        fork
            begin send(0, 8'h3C, ta); send(0, 8'hB5, ta); end
            begin send(1, 8'hDB, tb); send(1, 8'h0F, tb); end
        join
        wait_done(4);
        chk("t2_g0", gl[0], 0);
        chk("t2_g1", gl[1], 1);
        chk("t2_g2", gl[2], 0);
        chk("t2_id0", di_q[0], gl[0]);
        chk("t2_id1", di_q[1], gl[1]);
        chk("t2_id2", di_q[2], gl[2]);
        chk("t2_gap", dl_q[1] - dl_q[0], W + 3);

        // 16-bit instance with 2-bit saturating counter
        bzc = 0;
        b0d = 16'b1011_0110_1101_1011;
        b0v = 1'b1;
        ta = -1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (b0r) begin ta = cyc + 1; break; end
        end
        chk("t3_accept", ta >= 0, 1);
        @(posedge clk);
        #1;
        b0v = 1'b0;
        td = -1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (b_done) begin td = cyc + 1; tc = b_cnt; n0 = b_did; break; end
        end
        chk("t3_latency", td - ta, 18);
        chk("t3_cnt", tc, 3);
        chk("t3_id", n0, 0);
        chk("t3_z_pulses", bzc, 5);
        @(posedge clk);
        #1;

        // forced det_z outside SHIFT must not count
        clear_logs();
        z_force = 1'b1;
        send(0, 8'b1011_0110, t0);
        wait_done(1);
        chk("t5_cnt", dc_q[0], 2);
        z_force = 1'b0;

        // reset during the third SHIFT bit
        clear_logs();
        send(0, 8'hFF, t0);
        n0 = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (det_en) n0++;
            if (n0 == 3) break;
        end
        chk("t4_reached_bit3", n0, 3);
        #2;
        rst = 1'b0;
        #1;
        chk("t4_outs_zero",
            {r0r, r1r, det_clr, det_en, det_x, busy, done, match_cnt}, 0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        chk("t4_no_done", dl_q.size(), 0);
        gl.delete();
        fork
            send(0, 8'h5A, ta);
            send(1, 8'hB0, tb);
        join
        wait_done(2);
        chk("t4_ptr_reset", gl[0], 0);
        chk("t4_id", di_q[1], 1);
        chk("t4_cnt", dc_q[1], 1);

        // req1 raised mid-SHIFT of a req0 word
        clear_logs();
        fork
            send(0, 8'hD3, t0);
            begin
                for (int i = 0; i < 40; i++) begin
                    @(negedge clk);
                    if (det_en) break;
                end
                @(posedge clk);
                #1;
                send(1, 8'h6D, t1);
            end
        join
        wait_done(2);
        chk("t6_accept_after_done", t1 - dl_q[0], 1);
        chk("t6_id", di_q[1], 1);
        chk("t6_cnt", dc_q[1], win_count(16'h006D, 8));

        // randomized traffic with random det_z outside SHIFT
        rnd_on = 1'b1;
        for (int k = 0; k < 25; k++) begin
            fork
                rnd_req(0);
                rnd_req(1);
            join
        end
        rnd_on = 1'b0;
        z_force = 1'b0;
        repeat (15) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
